// File: rtl/vblank_scheduler_pkg.sv
// Shared types and constants for the vertical-blank update scheduler.
package vblank_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

  // Client slots in scan order; lower index is served first.
  localparam int CL_PLAYER   = 0;
  localparam int CL_INVADERS = 1;
  localparam int CL_BULLETS  = 2;
  localparam int CL_SCORE    = 3;

endpackage

// File: rtl/vblank_scheduler_edge_detect.sv
// One-bit registered edge detector; rise/fall are valid in the cycle the input changes.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;
  logic sig_q;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/vblank_scheduler.sv
// Grants game-logic clients one at a time at each vertical-blank start and
// flags frames where the work spills into active video or a client stalls.
module vblank_scheduler
  import vblank_scheduler_pkg::*;
#(
  parameter int N_CLIENTS   = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vblnk,
  input  logic [N_CLIENTS-1:0]   req,
  input  logic [N_CLIENTS-1:0]   done,
  input  logic                   clr_err,
  output logic [N_CLIENTS-1:0]   start,
  output logic                   busy,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   overrun,
  output logic [N_CLIENTS-1:0]   timeout_err,
  output sched_state_t           state_dbg
);

  localparam int IDX_W = $clog2(N_CLIENTS + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [N_CLIENTS-1:0] ONE_HOT0 = {{(N_CLIENTS-1){1'b0}}, 1'b1};

  // Handshake: start[i] is a one-cycle pulse; the client answers with done[i]
  // (pulse or level) in any later cycle. done[i] is only looked at while the
  // scheduler is waiting on client i, so stale or foreign done bits are harmless.

  sched_state_t           state_d, state_q;
  logic [IDX_W-1:0]       idx_d, idx_q;
  logic [TMR_W-1:0]       timer_d, timer_q;
  logic [N_CLIENTS-1:0]   start_d, start_q;
  logic                   busy_d, busy_q;
  logic                   frame_tick_d, frame_tick_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d, frame_cnt_q;
  logic                   overrun_d, overrun_q;
  logic [N_CLIENTS-1:0]   timeout_d, timeout_q;
  logic                   armed_d, armed_q;

  logic                   rise, fall, rise_ok;
  logic [N_CLIENTS-1:0]   sel;
  logic                   req_hit, done_hit, in_seq;
  logic [N_CLIENTS-1:0]   tmo_set;

  edge_detect u_vblnk_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (vblnk),
    .rise (rise),
    .fall (fall)
  );

  // A blank already in progress at reset release must not count as a frame.
  assign rise_ok  = rise & armed_q;
  assign sel      = (idx_q < IDX_W'(N_CLIENTS)) ? (ONE_HOT0 << idx_q) : '0;
  assign req_hit  = |(req & sel);
  assign done_hit = |(done & sel);
  assign in_seq   = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    start_d      = '0;
    tmo_set      = '0;
    frame_tick_d = rise_ok;
    frame_cnt_d  = frame_cnt_q + {{(FRAME_CNT_W-1){1'b0}}, rise_ok};
    armed_d      = armed_q | ~vblnk;

    case (state_q)
      IDLE: begin
        if (rise_ok) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(N_CLIENTS)) begin
          state_d = IDLE;
        end else if (!req_hit) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_d = sel;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (done_hit) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = SCAN;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          tmo_set = sel;
          idx_d   = idx_q + IDX_W'(1);
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Error set wins over a simultaneous clear.
    overrun_d = (clr_err ? 1'b0 : overrun_q) | (in_seq & (fall | rise_ok));
    timeout_d = (clr_err ? '0 : timeout_q) | tmo_set;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      start_q      <= '0;
      busy_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      armed_q      <= armed_d;
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign frame_tick  = frame_tick_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Randomized self-checking bench for vblank_scheduler with a per-frame timing model.
module tb_vblank_scheduler;
  import vblank_scheduler_pkg::*;

  localparam int NC  = 4;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          vblnk, clr_err;
  logic [NC-1:0] req, done;
  logic [NC-1:0] start, timeout_err;
  logic          busy, frame_tick, overrun;
  logic [15:0]   frame_cnt;
  sched_state_t  state_dbg;

  vblank_scheduler #(.N_CLIENTS(NC), .TIMEOUT_CYC(TMO), .FRAME_CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .vblnk       (vblnk),
    .req         (req),
    .done        (done),
    .clr_err     (clr_err),
    .start       (start),
    .busy        (busy),
    .frame_tick  (frame_tick),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic        vbl_at_edge = 1'b0;
  logic [NC-1:0] prev_start = '0;
  int          busy_last = -1;
  int          lat [NC];            // done delay per client, 0 = never answers
  int          cnt [NC];
  logic [31:0] exp_q[$];            // {cycle, start one-hot}
  logic [31:0] got_q[$];
  int          exp_tick_q[$];
  int          tick_q[$];
  logic [NC-1:0] tmo_exp = '0;
  logic        ovr_exp = 1'b0;
  int          frames_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    vbl_at_edge = vblnk;
  end

  // Monitor plus every-cycle protocol properties.
  always @(negedge clk) begin
    if (start != '0) got_q.push_back({cyc[27:0], start});
    if (frame_tick) begin
      tick_q.push_back(cyc);
      check("tick_follows_vblnk", {31'd0, vbl_at_edge}, 32'd1);
    end
    if (busy) busy_last = cyc;
    check("start_onehot0", {31'd0, $onehot0(start)}, 32'd1);
    check("start_back_to_back", {28'd0, start & prev_start}, 32'd0);
    prev_start = start;
  end

  // Done responders: pulse done[i] lat[i] cycles after start[i] is seen.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      done[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) done[i] = 1'b1;
      end
      if (start[i] && lat[i] != 0) cnt[i] = lat[i];
    end
  end

  // ---------------- reference model ----------------
  // Frame whose first SCAN cycle is f: skipped client costs 1 cycle, a served
  // client's start lands 2 cycles after its scan, and the scan resumes the cycle
  // after done (or after the 16th waiting cycle). Returns the last busy cycle.
  function automatic int model_seq(input int f, input logic [NC-1:0] r);
    int s, c;
    s = f;
    for (int i = 0; i < NC; i++) begin
      if (!r[i]) begin
        s = s + 1;
      end else begin
        c = s + 2;
        exp_q.push_back({c[27:0], 4'(1 << i)});
        if (lat[i] >= 1 && lat[i] <= TMO - 1) begin
          s = c + lat[i] + 1;
        end else begin
          s = c + TMO;
          tmo_exp[i] = 1'b1;
        end
      end
    end
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic compare_queues();
    check("start_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("start_event", got_q[i], exp_q[i]);
    check("tick_count", tick_q.size(), exp_tick_q.size());
    for (int i = 0; i < exp_tick_q.size() && i < tick_q.size(); i++)
      check("tick_cycle", tick_q[i], exp_tick_q[i]);
    exp_q.delete(); got_q.delete(); exp_tick_q.delete(); tick_q.delete();
  endtask

  task automatic compare_frame(input int s);
    compare_queues();
    check("busy_last_cycle", busy_last, s);
    check("frame_cnt", {16'd0, frame_cnt}, frames_exp);
    check("timeout_err", {28'd0, timeout_err}, {28'd0, tmo_exp});
    check("overrun", {31'd0, overrun}, {31'd0, ovr_exp});
  endtask

  task automatic run_frame(input logic [NC-1:0] r, input int high, input int low);
    int f, s;
    @(negedge clk);
    req   = r;
    vblnk = 1'b1;
    f = cyc + 1;
    exp_tick_q.push_back(f);
    frames_exp++;
    s = model_seq(f, r);
    if (f - 1 + high <= s) ovr_exp = 1'b1;
    repeat (high) @(negedge clk);
    vblnk = 1'b0;
    repeat (low) @(negedge clk);
    compare_frame(s);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    tmo_exp = '0;
    ovr_exp = 1'b0;
    check("clr_timeout_err", {28'd0, timeout_err}, 32'd0);
    check("clr_overrun", {31'd0, overrun}, 32'd0);
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f, s, c2;
    rst = 1'b1; vblnk = 1'b0; req = '0; clr_err = 1'b0;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    set_lat(3, 3, 3, 3);
    repeat (5) @(negedge clk);
    check("rst_start", {28'd0, start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_timeout", {28'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // All clients, then a skip pattern.
    run_frame(4'b1111, 100, 200);
    run_frame(4'b0101, 100, 200);

    // Client 1 never answers: timeout on bit 1 only, client 2 still served.
    set_lat(3, 0, 3, 3);
    run_frame(4'b1111, 100, 200);
    pulse_clr();

    // Random request masks and done latencies (some past the timeout).
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NC; i++) lat[i] = $urandom_range(0, 20);
      run_frame(4'($urandom_range(0, 15)), 100, 200);
    end
    pulse_clr();

    // Client 0 stalls while vblnk falls: overrun, sequence still completes.
    set_lat(0, 3, 3, 3);
    run_frame(4'b1111, 10, 200);
    pulse_clr();

    // Fall and a second rise while busy: tick and count, no restart.
    set_lat(0, 0, 0, 0);
    @(negedge clk);
    req = 4'b1111; vblnk = 1'b1;
    f = cyc + 1;
    exp_tick_q.push_back(f);
    frames_exp++;
    s = model_seq(f, 4'b1111);
    repeat (5) @(negedge clk);
    vblnk = 1'b0;
    ovr_exp = 1'b1;
    repeat (5) @(negedge clk);
    vblnk = 1'b1;
    exp_tick_q.push_back(cyc + 1);
    frames_exp++;
    repeat (100) @(negedge clk);
    vblnk = 1'b0;
    repeat (200) @(negedge clk);
    compare_frame(s);
    pulse_clr();

    // Reset while waiting on client 2.
    set_lat(3, 3, 0, 3);
    @(negedge clk);
    req = 4'b1111; vblnk = 1'b1;
    f = cyc + 1;
    exp_tick_q.push_back(f);
    s = model_seq(f, 4'b1111);
    c2 = int'(exp_q[2] >> 4);
    while (cyc < c2 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_start", {28'd0, start}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    void'(exp_q.pop_back());
    compare_queues();
    frames_exp = 0; tmo_exp = '0; ovr_exp = 1'b0;
    // vblnk is still high after release: no frame may start.
    repeat (20) @(negedge clk);
    check("no_tick_after_rst", tick_q.size(), 0);
    check("idle_after_rst", {31'd0, busy}, 32'd0);
    vblnk = 1'b0;
    repeat (30) @(negedge clk);
    set_lat(3, 3, 3, 3);
    run_frame(4'b1111, 100, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
